// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin-change payout FSM over denominations 10/5/2/1.
// Ports: clk; reset (async, active-low); change_valid/change_amount request;
//   coin_ack from the hopper; restock reloads stock; coin_out (one-hot)
//   with coin_valid to the hopper; busy; done (1-cycle pulse);
//   short/short_amount report change that stock could not cover.
// Build option: define CHANGE_STOCK_EN for per-denomination stock counters.
module change_dispenser (
    input  logic       clk,
    input  logic       reset,
    input  logic       change_valid,
    input  logic [3:0] change_amount,
    input  logic       coin_ack,
    input  logic       restock,
    output logic [3:0] coin_out,
    output logic       coin_valid,
    output logic       busy,
    output logic       done,
    output logic       short,
    output logic [3:0] short_amount
);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        ISSUE,
        DONE,
        SHORT
    } state_t;

    state_t     state_q;
    logic [3:0] rem_q;
    logic [3:0] coin_q;
    logic       valid_q;
    logic       busy_q;
    logic       done_q;
    logic [3:0] avail;
    logic [3:0] pick;

    // Coin value of a one-hot coin code (bit0=1, bit1=2, bit2=5, bit3=10).
    function automatic logic [3:0] coin_val(input logic [3:0] c);
        case (c)
            4'b0001: coin_val = 4'd1;
            4'b0010: coin_val = 4'd2;
            4'b0100: coin_val = 4'd5;
            4'b1000: coin_val = 4'd10;
            default: coin_val = 4'd0;
        endcase
    endfunction

`ifdef CHANGE_STOCK_EN
    logic [3:0][3:0] stock_q;
    logic [3:0][3:0] stock_d;
    logic            short_q;
    logic [3:0]      short_amt_q;

    // Restock overrides a coincident decrement.
    always_comb begin
        stock_d = stock_q;
        if (restock) begin
            stock_d = {4{4'd5}};
        end else if (state_q == ISSUE && coin_ack) begin
            for (int i = 0; i < 4; i++) begin
                if (coin_q[i]) stock_d[i] = stock_q[i] - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stock_q <= {4{4'd5}};
        else        stock_q <= stock_d;
    end

    always_comb begin
        avail = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            avail[i] = (stock_q[i] != 4'd0);
        end
    end

    assign short        = short_q;
    assign short_amount = short_amt_q;
`else
    wire unused_restock = restock;

    assign avail        = 4'b1111;
    assign short        = 1'b0;
    assign short_amount = 4'd0;
`endif

    // Largest available denomination not exceeding the remaining change.
    always_comb begin
        pick = 4'b0000;
        if (avail[3] && rem_q >= 4'd10)     pick = 4'b1000;
        else if (avail[2] && rem_q >= 4'd5) pick = 4'b0100;
        else if (avail[1] && rem_q >= 4'd2) pick = 4'b0010;
        else if (avail[0] && rem_q >= 4'd1) pick = 4'b0001;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rem_q   <= 4'd0;
            coin_q  <= 4'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef CHANGE_STOCK_EN
            short_q     <= 1'b0;
            short_amt_q <= 4'd0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (change_valid) begin
                        rem_q   <= change_amount;
                        busy_q  <= 1'b1;
                        state_q <= SELECT;
                    end
                end
                SELECT: begin
                    if (rem_q == 4'd0) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (pick != 4'd0) begin
                        coin_q  <= pick;
                        valid_q <= 1'b1;
                        state_q <= ISSUE;
                    end
`ifdef CHANGE_STOCK_EN
                    else begin
                        busy_q      <= 1'b0;
                        short_q     <= 1'b1;
                        short_amt_q <= rem_q;
                        state_q     <= SHORT;
                    end
`endif
                end
                ISSUE: begin
                    if (coin_ack) begin
                        rem_q   <= rem_q - coin_val(coin_q);
                        coin_q  <= 4'd0;
                        valid_q <= 1'b0;
                        state_q <= SELECT;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                SHORT: begin
`ifdef CHANGE_STOCK_EN
                    if (restock) begin
                        short_q     <= 1'b0;
                        short_amt_q <= 4'd0;
                        state_q     <= IDLE;
                    end
`else
                    state_q <= IDLE;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign coin_out   = coin_q;
    assign coin_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: scoreboard bench for change_dispenser.
// Stimulus pushes expected coin/done/short events; a monitor pops and compares.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       change_valid = 1'b0;
    logic [3:0] change_amount = 4'd0;
    logic       coin_ack = 1'b0;
    logic       restock = 1'b0;
    logic [3:0] coin_out;
    logic       coin_valid;
    logic       busy;
    logic       done;
    logic       short;
    logic [3:0] short_amount;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] val;
    } ev_t;

    localparam logic [1:0] K_COIN  = 2'd0;
    localparam logic [1:0] K_DONE  = 2'd1;
    localparam logic [1:0] K_SHORT = 2'd2;

    ev_t exp_q[$];
    bit  ack_en = 1'b1;

    always #5 clk = ~clk;

    change_dispenser dut (
        .clk          (clk),
        .reset        (reset),
        .change_valid (change_valid),
        .change_amount(change_amount),
        .coin_ack     (coin_ack),
        .restock      (restock),
        .coin_out     (coin_out),
        .coin_valid   (coin_valid),
        .busy         (busy),
        .done         (done),
        .short        (short),
        .short_amount (short_amount)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic expect_ev(input logic [1:0] k, input logic [3:0] v);
        ev_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: got kind %0d val %b, expected nothing",
                     k, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== k || e.val !== v) begin
                n_fail++;
                $display("FAIL scoreboard: got kind %0d val %b, expected kind %0d val %b",
                         k, v, e.kind, e.val);
            end
        end
    endtask

    // Monitor: one event per coin presentation, done pulse or short entry.
    logic prev_v = 1'b0;
    logic prev_s = 1'b0;
    always @(negedge clk) begin
        if (coin_valid && !prev_v) expect_ev(K_COIN, coin_out);
        if (done) expect_ev(K_DONE, 4'd0);
        if (short && !prev_s) expect_ev(K_SHORT, short_amount);
        prev_v = coin_valid;
        prev_s = short;
    end

    // Hopper model: holds each coin three sampling points, then acks.
    logic [3:0] held = 4'd0;
    int         hold_cnt = 0;
    always @(negedge clk) begin
        if (coin_valid) begin
            if (hold_cnt == 0) held = coin_out;
            else check("coin_hold", coin_out, held);
            hold_cnt++;
            coin_ack = ack_en && (hold_cnt >= 3);
        end else begin
            hold_cnt = 0;
            coin_ack = 1'b0;
        end
    end

    task automatic push(input logic [1:0] k, input logic [3:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    // Returns at the negedge after the accepting edge.
    task automatic request(input logic [3:0] amt);
        @(negedge clk);
        change_amount = amt;
        change_valid  = 1'b1;
        @(negedge clk);
        change_valid  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no done pulse within 200 cycles", name);
        end
    endtask

    task automatic pay(input logic [3:0] amt, input string name);
        request(amt);
        wait_done(name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_coin_out", coin_out, 4'd0);
        check("rst_coin_valid", coin_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_short", short, 1'b0);
        check("rst_short_amount", short_amount, 4'd0);
        reset = 1'b1;

        // 13 -> 10, 2, 1
        push(K_COIN, 4'b1000);
        push(K_COIN, 4'b0010);
        push(K_COIN, 4'b0001);
        push(K_DONE, 4'd0);
        request(4'd13);
        check("t13_busy_select", busy, 1'b1);
        check("t13_valid_early", coin_valid, 1'b0);
        @(negedge clk);
        check("t13_first_valid", coin_valid, 1'b1);
        check("t13_first_coin", coin_out, 4'b1000);
        wait_done("t13");
        check("t13_busy_done", busy, 1'b1);
        @(negedge clk);
        check("t13_busy_after", busy, 1'b0);
        check("t13_done_after", done, 1'b0);

        // 0 -> done two edges after accept, no coin
        push(K_DONE, 4'd0);
        request(4'd0);
        check("t0_busy1", busy, 1'b1);
        check("t0_done_early", done, 1'b0);
        @(negedge clk);
        check("t0_busy2", busy, 1'b1);
        check("t0_done", done, 1'b1);
        @(negedge clk);
        check("t0_busy_after", busy, 1'b0);
        check("t0_done_after", done, 1'b0);

        // 9 with an ignored request for 7 while ISSUE is pending
        push(K_COIN, 4'b0100);
        push(K_COIN, 4'b0010);
        push(K_COIN, 4'b0010);
        push(K_DONE, 4'd0);
        ack_en = 1'b0;
        request(4'd9);
        @(negedge clk);
        check("t9_valid", coin_valid, 1'b1);
        change_amount = 4'd7;
        change_valid  = 1'b1;
        repeat (3) @(negedge clk);
        change_valid  = 1'b0;
        ack_en = 1'b1;
        wait_done("t9");
        repeat (12) @(negedge clk);
        check("t9_idle_busy", busy, 1'b0);
        check("t9_queue", exp_q.size(), 0);

        // Asynchronous reset while a coin is presented
        push(K_COIN, 4'b1000);
        ack_en = 1'b0;
        request(4'd12);
        @(negedge clk);
        check("rst_mid_valid_before", coin_valid, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_valid", coin_valid, 1'b0);
        check("rst_mid_coin", coin_out, 4'd0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_queue", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        ack_en = 1'b1;
        push(K_COIN, 4'b1000);
        push(K_COIN, 4'b0010);
        push(K_DONE, 4'd0);
        pay(4'd12, "t12_fresh");
        @(negedge clk);

`ifdef CHANGE_STOCK_EN
        // Fresh stocks via reset
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Tens run out after five payouts
        for (int i = 0; i < 5; i++) begin
            push(K_COIN, 4'b1000);
            push(K_DONE, 4'd0);
            pay(4'd10, "s10");
        end
        push(K_COIN, 4'b0100);
        push(K_COIN, 4'b0100);
        push(K_DONE, 4'd0);
        pay(4'd10, "s10_sixth");
        // Three fives left: 15 -> 5,5,5, then 5 -> 2,2,1
        for (int i = 0; i < 3; i++) push(K_COIN, 4'b0100);
        push(K_DONE, 4'd0);
        pay(4'd15, "s15");
        push(K_COIN, 4'b0010);
        push(K_COIN, 4'b0010);
        push(K_COIN, 4'b0001);
        push(K_DONE, 4'd0);
        pay(4'd5, "s5_nofives");
        @(negedge clk);
        restock = 1'b1;
        @(negedge clk);
        restock = 1'b0;

        // Exhaust twos and ones
        for (int i = 0; i < 2; i++) begin
            push(K_COIN, 4'b0010);
            push(K_COIN, 4'b0010);
            push(K_DONE, 4'd0);
            pay(4'd4, "s4_twos");
        end
        push(K_COIN, 4'b0010);
        push(K_COIN, 4'b0001);
        push(K_DONE, 4'd0);
        pay(4'd3, "s3_last_two");
        for (int i = 0; i < 4; i++) push(K_COIN, 4'b0001);
        push(K_DONE, 4'd0);
        pay(4'd4, "s4_ones");

        // Shortage
        push(K_SHORT, 4'd3);
        request(4'd3);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (short) seen = 1'b1;
            end
            check("short_seen", seen, 1'b1);
        end
        repeat (3) @(negedge clk);
        check("short_flag", short, 1'b1);
        check("short_amount", short_amount, 4'd3);
        check("short_busy", busy, 1'b0);
        restock = 1'b1;
        @(negedge clk);
        restock = 1'b0;
        check("restock_short", short, 1'b0);
        check("restock_amount", short_amount, 4'd0);
        check("restock_busy", busy, 1'b0);
        push(K_COIN, 4'b0010);
        push(K_COIN, 4'b0001);
        push(K_DONE, 4'd0);
        pay(4'd3, "s3_restocked");
        @(negedge clk);
`endif

        repeat (5) @(negedge clk);
        check("final_queue", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
